// File: rtl/rv32i_mem_pkg.sv
// rv32i_mem_pkg: shared FSM encoding and byte-lane constants for the data-memory responder
package rv32i_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int BE_W     = 4;
    localparam int WORD_OFF = 2;

endpackage

// File: rtl/rv32i_dmem_bank.sv
// rv32i_dmem_bank: word RAM with one byte-lane-enabled synchronous write port and an async read port
module rv32i_dmem_bank
    import rv32i_mem_pkg::*;
#(
    parameter int  DEPTH_WORDS = 64,
    localparam int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [31:0]     wdata_i,
    input  logic [BE_W-1:0] be_i,
    output logic [31:0]     rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++)
            if (we_i && be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/rv32i_dmem_responder.sv
// rv32i_dmem_responder: LSU-side data memory responder with programmable wait states
module rv32i_dmem_responder
    import rv32i_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [BE_W-1:0] be_q, be_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            accept, commit, hshake, below, addr_err;
    logic [31:0]     off, ram_rdata;

    assign accept = req_valid && state_q == ST_IDLE;
    assign commit = state_q == ST_WAIT && cnt_q == 4'd0;
    assign hshake = rsp_valid_q && rsp_ready;

    // 33-bit subtract: the borrow flags addresses below the base, and the range check gates RAM access
    assign {below, off} = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    assign addr_err = (addr_q[1:0] != 2'b00) || below || ((off >> WORD_OFF) >= 32'(DEPTH_WORDS));

    rv32i_dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
        .clk    (clk),
        .we_i   (commit && we_q && !addr_err),
        .addr_i (off[AW+WORD_OFF-1:WORD_OFF]),
        .wdata_i(wdata_q),
        .be_i   (be_q),
        .rdata_o(ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // WAIT always lasts WAIT_CYCLES+1 cycles, so the commit edge lands WAIT_CYCLES+1 edges after accept
    always_comb begin
        state_d = (state_q == ST_IDLE) ? (req_valid ? ST_WAIT : ST_IDLE) :
                  (state_q == ST_WAIT) ? (commit ? ST_RESP : ST_WAIT) :
                  (hshake ? ST_IDLE : ST_RESP);
        cnt_d   = accept ? 4'(WAIT_CYCLES) :
                  (state_q == ST_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    end

    always_comb begin
        we_d        = accept ? req_we : we_q;
        addr_d      = accept ? req_addr : addr_q;
        wdata_d     = accept ? req_wdata : wdata_q;
        be_d        = accept ? req_be : be_q;
        rsp_valid_d = commit || (rsp_valid_q && !hshake);
        rsp_err_d   = commit ? addr_err : (hshake ? 1'b0 : rsp_err_q);
        rsp_rdata_d = commit ? ((we_q || addr_err) ? 32'h0 : ram_rdata) :
                      (hshake ? 32'h0 : rsp_rdata_q);
    end

    assign req_ready = state_q == ST_IDLE;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// tb_rv32i_dmem_responder: randomized check of the responder against a word-array reference model
module tb_rv32i_dmem_responder;

    localparam int          DEPTH    = 64;
    localparam int          WC       = 1;
    localparam logic [31:0] ALT_BASE = 32'h100;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mem [DEPTH];

    always #5 clk = ~clk;

    rv32i_dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (32'h0),
        .WAIT_CYCLES(WC)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic m_err(input logic [31:0] a, input logic [31:0] base, input int depth);
        return (a[1:0] != 2'b00) || (a < base) || (((a - base) >> 2) >= 32'(depth));
    endfunction

    task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int stall, input string tag);
        logic [31:0] exp_d, held;
        logic        exp_e;
        int          lat;
        exp_e = m_err(a, 32'h0, DEPTH);
        exp_d = (we || exp_e) ? 32'h0 : mem[a[7:2]];
        if (we && !exp_e)
            for (int i = 0; i < 4; i++) if (be[i]) mem[a[7:2]][8*i +: 8] = d[8*i +: 8];
        @(negedge clk);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        rsp_ready = (stall == 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_be = 4'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!rsp_valid && lat < 40);
        chk({tag, "_lat"}, 32'(lat), 32'(WC + 1));
        chk({tag, "_rdata"}, rsp_rdata, exp_d);
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
        held = rsp_rdata;
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata, held);
            chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_clr_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_clr_rdata"}, rsp_rdata, 32'h0);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_alt
        localparam int AWC = (g == 0) ? 0 : 15;
        logic        rst_a, v, rdy, we, rv, err, done;
        logic [31:0] ad, wd, rd;
        logic [3:0]  be;

        rv32i_dmem_responder #(
            .DEPTH_WORDS(16),
            .BASE_ADDR  (ALT_BASE),
            .WAIT_CYCLES(AWC)
        ) u_alt (
            .clk      (clk),
            .reset    (rst_a),
            .req_valid(v),
            .req_ready(rdy),
            .req_we   (we),
            .req_addr (ad),
            .req_wdata(wd),
            .req_be   (be),
            .rsp_valid(rv),
            .rsp_ready(1'b1),
            .rsp_rdata(rd),
            .rsp_err  (err)
        );

        initial begin
            logic [31:0] data [3];
            logic [31:0] a, ed;
            logic        ee;
            int          lat;
            done = 1'b0; rst_a = 1'b1; v = 1'b0; we = 1'b0; ad = '0; wd = '0; be = '0;
            repeat (2) @(negedge clk);
            rst_a = 1'b0;
            for (int k = 0; k < 8; k++) begin
                a  = (k == 6) ? ALT_BASE - 32'd4 : (k == 7) ? ALT_BASE + 32'd64 :
                     ALT_BASE + 32'(4 * (k % 3));
                if (k < 3) data[k] = $urandom;
                ee = m_err(a, ALT_BASE, 16);
                ed = (k >= 3 && k < 6) ? data[k-3] : 32'h0;
                @(negedge clk);
                chk("alt_ready", 32'(rdy), 32'd1);
                v = 1'b1; we = (k < 3); ad = a; wd = (k < 3) ? data[k] : 32'h0; be = 4'hF;
                @(posedge clk);
                #1 v = 1'b0;
                lat = 0;
                do begin
                    @(posedge clk);
                    lat++;
                    @(negedge clk);
                end while (!rv && lat < 40);
                chk("alt_lat", 32'(lat), 32'(AWC + 1));
                chk("alt_rdata", rd, ed);
                chk("alt_err", 32'(err), 32'(ee));
                @(posedge clk);
            end
            done = 1'b1;
        end
    end

    initial begin
        logic [31:0] a;
        int          r;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_be = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(4 * i), $urandom, 4'hF, 0, "fill");
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "t1_st");
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, "t1_ld");
        xact(1'b1, 32'h14, 32'h11223344, 4'hF, 0, "t2_st0");
        xact(1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, 0, "t2_st1");
        xact(1'b0, 32'h14, 32'h0, 4'h0, 0, "t2_ld");
        chk("t2_model", mem[5], 32'h11BB33DD);
        xact(1'b0, 32'h12, 32'h0, 4'h0, 0, "t3_mis");
        xact(1'b1, 32'h100, 32'h12345678, 4'hF, 0, "t3_oor");
        xact(1'b0, 32'h0, 32'h0, 4'h0, 0, "t3_ld0");
        xact(1'b1, 32'h18, 32'hCAFEF00D, 4'h0, 0, "t3_be0");
        xact(1'b0, 32'h18, 32'h0, 4'h0, 5, "t4_bp");
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, "t4_next");
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = ~mem[8]; req_be = 4'hF;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_ready", 32'(req_ready), 32'd1);
        chk("t6_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
        end
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0, "t6_ld");
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 9);
            a = {24'h0, 2'($urandom), 4'($urandom), 2'b00};
            if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (r == 1) a = 32'h100 + {$urandom_range(0, 1000), 2'b00};
            xact(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), "rnd");
        end
        for (int i = 0; i < 3000 && !(g_alt[0].done && g_alt[1].done); i++) @(negedge clk);
        chk("alt_done", {30'h0, g_alt[1].done, g_alt[0].done}, 32'h3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
